video_pattern_gen: RTL

- Video source for the RGB pixel pipeline. Generates hsync, vsync, VDE and 24-bit pixel data on the same interface the pixel-processing filters consume.
- Replaces the HDMI input during bring-up and regression, so downstream filters (skin detection, colour conversion) see a deterministic frame.
- Pixel packing is {R[23:16], B[15:8], G[7:0]}, the same as the rest of the pipeline.

---
 rtl/video_pattern_gen.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/video_pattern_gen.sv
// video_pattern_gen
// Deterministic video source for the RGB pixel pipeline. Produces hsync,
// vsync, VDE and 24-bit {R,B,G} pixel data from free-running raster
// counters, with four selectable test patterns (solid skin tone, colour
// bars, grey ramp, checkerboard).
//
// Optional build macro: VPG_MOVING_BOX_EN
//   When defined, a BOX_SIZE x BOX_SIZE skin-tone box is overlaid on every
//   pattern along the top of the frame, stepping one pixel right per frame.
//   When undefined, no box logic is built and only the base pattern is output.
//
// Every output is registered one clock after the counter state it decodes,
// so all outputs stay mutually aligned.

module video_pattern_gen #(
   parameter int   H_ACTIVE    = 1280,
   parameter int   H_FP        = 110,
   parameter int   H_SYNC      = 40,
   parameter int   H_BP        = 220,
   parameter int   V_ACTIVE    = 720,
   parameter int   V_FP        = 5,
   parameter int   V_SYNC      = 5,
   parameter int   V_BP        = 20,
   parameter logic HS_POL      = 1'b1,
   parameter logic VS_POL      = 1'b1,
   parameter int   CHECK_SHIFT = 5,
   parameter int   BOX_SIZE    = 64
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        en,
   input  logic [3:0]  sw,
   output logic [23:0] o_vid_data,
   output logic        o_vid_hsync,
   output logic        o_vid_vsync,
   output logic        o_vid_VDE,
   output logic        o_frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   // Colour bars are tracked with a pixel-in-bar counter rather than a divider.
   localparam int BAR_W   = H_ACTIVE / 8;
   localparam int BW      = $clog2(BAR_W) + 1;

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);

   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

   // Pixel colours, packed {R,B,G}.
   localparam logic [23:0] C_SKIN    = {8'd224, 8'd140, 8'd172};
   localparam logic [23:0] C_WHITE   = {8'd255, 8'd255, 8'd255};
   localparam logic [23:0] C_YELLOW  = {8'd255, 8'd0,   8'd255};
   localparam logic [23:0] C_CYAN    = {8'd0,   8'd255, 8'd255};
   localparam logic [23:0] C_GREEN   = {8'd0,   8'd0,   8'd255};
   localparam logic [23:0] C_MAGENTA = {8'd255, 8'd255, 8'd0};
   localparam logic [23:0] C_RED     = {8'd255, 8'd0,   8'd0};
   localparam logic [23:0] C_BLUE    = {8'd0,   8'd255, 8'd0};
   localparam logic [23:0] C_BLACK   = 24'd0;

`ifndef VPG_MOVING_BOX_EN
   // Box size only matters when the overlay is built.
   localparam int unused_box_size = BOX_SIZE;
`endif

   // Upper switch bits are reserved and deliberately ignored.
   logic [1:0] unused_sw;
   assign unused_sw = sw[3:2];

   // Raster position, pattern register and bar tracker.
   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic [1:0]    pattern_q, pattern_d;
   logic [BW-1:0] bar_pix_q, bar_pix_d;
   logic [2:0]    bar_idx_q, bar_idx_d;

   // Registered outputs.
   logic [23:0]   data_q, data_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          vde_q, vde_d;
   logic          frame_start_q, frame_start_d;

`ifdef VPG_MOVING_BOX_EN
   logic [HW-1:0] box_x_q, box_x_d;
   logic          in_box;
`endif

   logic          frame_origin;
   logic          active;
   logic [1:0]    pattern_sel;
   logic [23:0]   bar_colour;
   logic [23:0]   base_pix;
   logic [23:0]   pix;

   // Decode the raster position and pick the pattern that applies to it;
   // a new selection takes effect exactly at the first pixel of a frame.
   always_comb begin
      frame_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
      active       = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      pattern_sel  = frame_origin ? sw[1:0] : pattern_q;
   end

   // Map the current bar index onto the standard eight-bar colour order.
   always_comb begin
      case (bar_idx_q)
         3'd0:    bar_colour = C_WHITE;
         3'd1:    bar_colour = C_YELLOW;
         3'd2:    bar_colour = C_CYAN;
         3'd3:    bar_colour = C_GREEN;
         3'd4:    bar_colour = C_MAGENTA;
         3'd5:    bar_colour = C_RED;
         3'd6:    bar_colour = C_BLUE;
         default: bar_colour = C_BLACK;
      endcase
   end

   // Generate the base pattern pixel for the current raster position.
   always_comb begin
      case (pattern_sel)
         2'd0:    base_pix = C_SKIN;
         2'd1:    base_pix = bar_colour;
         2'd2:    base_pix = {3{8'(h_cnt_q)}};
         default: base_pix = (h_cnt_q[CHECK_SHIFT] ^ v_cnt_q[CHECK_SHIFT]) ? C_MAGENTA : C_SKIN;
      endcase
   end

`ifdef VPG_MOVING_BOX_EN
   // Overlay the skin-tone box anchored at the top edge of the frame.
   always_comb begin
      in_box = (32'(v_cnt_q) < BOX_SIZE) &&
               (32'(h_cnt_q) >= 32'(box_x_q)) &&
               (32'(h_cnt_q) < 32'(box_x_q) + BOX_SIZE);
      pix    = in_box ? C_SKIN : base_pix;
   end
`else
   // Without the overlay the base pattern goes straight out.
   always_comb begin
      pix = base_pix;
   end
`endif

   // Next-state logic: advance the raster while enabled, otherwise hold the
   // position and drive idle outputs.
   always_comb begin
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      pattern_d     = pattern_q;
      bar_pix_d     = bar_pix_q;
      bar_idx_d     = bar_idx_q;
      data_d        = 24'd0;
      hsync_d       = ~HS_POL;
      vsync_d       = ~VS_POL;
      vde_d         = 1'b0;
      frame_start_d = 1'b0;
`ifdef VPG_MOVING_BOX_EN
      box_x_d       = box_x_q;
`endif

      if (en) begin
         pattern_d     = pattern_sel;
         vde_d         = active;
         data_d        = active ? pix : 24'd0;
         hsync_d       = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
         vsync_d       = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;
         frame_start_d = frame_origin;

         if (h_cnt_q == H_LAST) begin
            h_cnt_d   = '0;
            bar_pix_d = '0;
            bar_idx_d = 3'd0;
            if (v_cnt_q == V_LAST) begin
               v_cnt_d = '0;
`ifdef VPG_MOVING_BOX_EN
               if (32'(box_x_q) + 1 + BOX_SIZE > H_ACTIVE) begin
                  box_x_d = '0;
               end else begin
                  box_x_d = box_x_q + HW'(1);
               end
`endif
            end else begin
               v_cnt_d = v_cnt_q + VW'(1);
            end
         end else begin
            h_cnt_d = h_cnt_q + HW'(1);
            if (bar_idx_q != 3'd7) begin
               if (bar_pix_q == BAR_LAST) begin
                  bar_pix_d = '0;
                  bar_idx_d = bar_idx_q + 3'd1;
               end else begin
                  bar_pix_d = bar_pix_q + BW'(1);
               end
            end
         end
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         pattern_q     <= 2'd0;
         bar_pix_q     <= '0;
         bar_idx_q     <= 3'd0;
         data_q        <= 24'd0;
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
         vde_q         <= 1'b0;
         frame_start_q <= 1'b0;
`ifdef VPG_MOVING_BOX_EN
         box_x_q       <= '0;
`endif
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         pattern_q     <= pattern_d;
         bar_pix_q     <= bar_pix_d;
         bar_idx_q     <= bar_idx_d;
         data_q        <= data_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         vde_q         <= vde_d;
         frame_start_q <= frame_start_d;
`ifdef VPG_MOVING_BOX_EN
         box_x_q       <= box_x_d;
`endif
      end
   end

   assign o_vid_data    = data_q;
   assign o_vid_hsync   = hsync_q;
   assign o_vid_vsync   = vsync_q;
   assign o_vid_VDE     = vde_q;
   assign o_frame_start = frame_start_q;

endmodule
